// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- two-stage pipelined immediate generator (RV32I/RV64I).
//
// Takes raw instruction words, selects the immediate format from the opcode,
// reassembles the scattered immediate field and sign-extends it to XLEN.
// Stage S1 holds the raw instruction and tag; decode sits between S1 and S2;
// S2 holds the extended immediate, the format code and the tag.
//
// Optional feature macro: IMM_GEN_ZICSR_EN
//   defined   -> CSRRWI/CSRRSI/CSRRCI produce fmt Z with zero-extended uimm
//   undefined -> they decode as ordinary I-type (CSR address, sign-extended)
//
// Parameters: XLEN (32 or 64 only), TAG_W (sideband tag width)
// Ports:
//   clk        clock, rising edge
//   reset_n    synchronous active-low reset
//   flush      discards every in-flight entry at the next edge
//   in_valid   / in_ready   / in_inst / in_tag              upstream handshake
//   out_valid  / out_ready  / out_imm / out_fmt / out_tag   downstream handshake
//   out_fmt    0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [6:0] OPCODE_LOAD        = 7'b0000011;
  localparam logic [6:0] OPCODE_FENCE       = 7'b0001111;
  localparam logic [6:0] OPCODE_ITYPE       = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC       = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE       = 7'b0100011;
  localparam logic [6:0] OPCODE_LUI         = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH      = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR        = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL         = 7'b1101111;
  localparam logic [6:0] OPCODE_ENVIRONMENT = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  // Stage registers
  logic             s1_vld_q,  s1_vld_d;
  logic [31:0]      s1_inst_q, s1_inst_d;
  logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;
  logic             s2_vld_q,  s2_vld_d;
  logic [XLEN-1:0]  s2_imm_q,  s2_imm_d;
  logic [2:0]       s2_fmt_q,  s2_fmt_d;
  logic [TAG_W-1:0] s2_tag_q,  s2_tag_d;

  logic s2_adv, s1_adv;

  // Decode results
  logic [31:0]     dec_raw;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = s1_vld_q && s2_adv;
  // Sole combinational path from out_ready to in_ready.
  assign in_ready = !s1_vld_q || s2_adv;

  // Every format is first brought to a 32-bit two's-complement value; the
  // XLEN widening below is then a plain sign extension. For U-type that
  // extends from bit 31, and the Z uimm has a zero top bit so it stays
  // zero-extended.
  always_comb begin
    dec_raw = 32'd0;
    dec_fmt = FMT_NONE;
    unique case (s1_inst_q[6:0])
      OPCODE_JALR, OPCODE_LOAD, OPCODE_ITYPE, OPCODE_FENCE: begin
        dec_raw = {{20{s1_inst_q[31]}}, s1_inst_q[31:20]};
        dec_fmt = FMT_I;
      end
      OPCODE_ENVIRONMENT: begin
`ifdef IMM_GEN_ZICSR_EN
        if (s1_inst_q[14]) begin
          dec_raw = {27'd0, s1_inst_q[19:15]};
          dec_fmt = FMT_Z;
        end else begin
          dec_raw = {{20{s1_inst_q[31]}}, s1_inst_q[31:20]};
          dec_fmt = FMT_I;
        end
`else
        dec_raw = {{20{s1_inst_q[31]}}, s1_inst_q[31:20]};
        dec_fmt = FMT_I;
`endif
      end
      OPCODE_STORE: begin
        dec_raw = {{20{s1_inst_q[31]}}, s1_inst_q[31:25], s1_inst_q[11:7]};
        dec_fmt = FMT_S;
      end
      OPCODE_BRANCH: begin
        dec_raw = {{19{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[7],
                   s1_inst_q[30:25], s1_inst_q[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        dec_raw = {s1_inst_q[31:12], 12'd0};
        dec_fmt = FMT_U;
      end
      OPCODE_JAL: begin
        dec_raw = {{11{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[19:12],
                   s1_inst_q[20], s1_inst_q[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      default: begin
        dec_raw = 32'd0;
        dec_fmt = FMT_NONE;
      end
    endcase
  end

  assign dec_imm = XLEN'(signed'(dec_raw));

  // Next-state: S2 refills from S1 whenever it drains; S1 takes the input
  // whenever it is free (or emptying). Flush overrides both valid bits but
  // leaves data alone.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_inst_d = s1_inst_q;
    s1_tag_d  = s1_tag_q;
    s2_vld_d  = s2_vld_q;
    s2_imm_d  = s2_imm_q;
    s2_fmt_d  = s2_fmt_q;
    s2_tag_d  = s2_tag_q;

    if (s2_adv) s2_vld_d = s1_vld_q;
    if (in_ready) s1_vld_d = in_valid;

    if (in_valid && in_ready) begin
      s1_inst_d = in_inst;
      s1_tag_d  = in_tag;
    end
    if (s1_adv) begin
      s2_imm_d = dec_imm;
      s2_fmt_d = dec_fmt;
      s2_tag_d = s1_tag_q;
    end

    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_inst_q <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_imm_q  <= '0;
      s2_fmt_q  <= '0;
      s2_tag_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_inst_q <= s1_inst_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      s2_imm_q  <= s2_imm_d;
      s2_fmt_q  <= s2_fmt_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_imm   = s2_imm_q;
  assign out_fmt   = s2_fmt_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share all
// inputs. An arrival-ordered queue model predicts out_valid, in_ready and
// the output entry every cycle; directed sequences additionally compare the
// drained outputs against fixed known-good values.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [4:0]  in_tag;

  logic        rdy32, rdy64, ov32, ov64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [4:0]  tag32, tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_tag(tag64));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, obs, exp);
    end
  endtask

  // Reference: immediate as a mathematical integer, folded to 64-bit
  // two's complement. The 32-bit result is its low half.
  function automatic void ref_dec(input logic [31:0] i, output logic [63:0] imm,
                                  output logic [2:0] fmt);
    longint v = 0;
    fmt = 3'd0;
    case (i[6:0])
      7'h03, 7'h0F, 7'h13, 7'h67: begin
        fmt = 3'd1; v = longint'(i[31:20]); if (v >= 2048) v -= 4096;
      end
      7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
        if (i[14]) begin fmt = 3'd6; v = longint'(i[19:15]); end
        else begin fmt = 3'd1; v = longint'(i[31:20]); if (v >= 2048) v -= 4096; end
`else
        fmt = 3'd1; v = longint'(i[31:20]); if (v >= 2048) v -= 4096;
`endif
      end
      7'h23: begin
        fmt = 3'd2; v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
            longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4; v = longint'(i[31:12]) * 4096;
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: begin fmt = 3'd0; v = 0; end
    endcase
    imm = 64'(v);
  endfunction

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [4:0]  tag;
    int          acc;   // edge index at which it was accepted
  } ent_t;

  ent_t        q[$];
  int          ecount = 0;
  logic [31:0] log32[$];
  logic [63:0] log64[$];
  logic [2:0]  logf[$];
  logic [4:0]  logt[$];

  // One clock: called just after a negedge, returns just after the next.
  task automatic step(input bit iv, input logic [31:0] inst, input logic [4:0] tg,
                      input bit ordy, input bit fl, input bit rst, output bit fired);
    bit   exp_ov, fire_out;
    ent_t e;
    exp_ov = (q.size() > 0) && (q[0].acc + 2 <= ecount);
    chk("out_valid32", 64'(ov32), 64'(exp_ov));
    chk("out_valid64", 64'(ov64), 64'(exp_ov));
    if (exp_ov && ov32 && ov64) begin
      chk("imm32", 64'(imm32), 64'(q[0].imm[31:0]));
      chk("imm64", imm64, q[0].imm);
      chk("fmt32", 64'(fmt32), 64'(q[0].fmt));
      chk("fmt64", 64'(fmt64), 64'(q[0].fmt));
      chk("tag32", 64'(tag32), 64'(q[0].tag));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
    end
    in_valid = iv; in_inst = inst; in_tag = tg;
    out_ready = ordy; flush = fl; reset_n = !rst;
    #1;
    chk("in_ready32", 64'(rdy32), 64'((q.size() < 2) || ordy));
    chk("in_ready64", 64'(rdy64), 64'((q.size() < 2) || ordy));
    fired    = iv && rdy32 && !fl && !rst;
    fire_out = ov32 && ordy;
    if (fire_out) begin
      log32.push_back(imm32); log64.push_back(imm64);
      logf.push_back(fmt32);  logt.push_back(tag32);
    end
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      if (fire_out && q.size() > 0) void'(q.pop_front());
      if (fired) begin
        ref_dec(inst, e.imm, e.fmt);
        e.tag = tg; e.acc = ecount;
        q.push_back(e);
      end
    end
    ecount++;
    @(negedge clk);
  endtask

  task automatic clr_log();
    log32.delete(); log64.delete(); logf.delete(); logt.delete();
  endtask

  logic [31:0] s_inst[4]  = '{32'hB9F02083, 32'hFE000EE3, 32'hDEADB017, 32'h002081B3};
  logic [31:0] s_e32[4]   = '{32'hFFFFFB9F, 32'hFFFFFFFC, 32'hDEADB000, 32'h0};
  logic [63:0] s_e64[4]   = '{64'hFFFFFFFFFFFFFB9F, 64'hFFFFFFFFFFFFFFFC,
                              64'hFFFFFFFFDEADB000, 64'h0};
  logic [2:0]  s_fmt[4]   = '{3'd1, 3'd3, 3'd4, 3'd0};
  logic [6:0]  ops[12]    = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                              7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};

  initial begin
    bit          f;
    int          nacc;
    logic [31:0] r;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1, f);
    step(0, 0, 0, 0, 0, 1, f);

    // Reset state
    chk("rst_ov", 64'(ov32), 64'd0);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_fmt", 64'(fmt32), 64'd0);
    chk("rst_tag", 64'(tag64), 64'd0);
    chk("rst_inrdy", 64'(rdy32), 64'd1);

    // ADDI, two edges of latency
    step(1, 32'h13600093, 5'd7, 1, 0, 0, f);
    chk("addi_lat1", 64'(ov32), 64'd0);
    step(0, 0, 0, 1, 0, 0, f);
    chk("addi_vld", 64'(ov32), 64'd1);
    chk("addi_imm", 64'(imm32), 64'h136);
    chk("addi_fmt", 64'(fmt32), 64'd1);
    chk("addi_tag", 64'(tag32), 64'd7);
    step(0, 0, 0, 1, 0, 0, f);

    // Back-to-back stream, both widths
    clr_log();
    for (int k = 0; k < 4; k++) step(1, s_inst[k], 5'(k + 1), 1, 0, 0, f);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, f);
    chk("strm_cnt", 64'(log32.size()), 64'd4);
    if (log32.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("strm_imm32_%0d", k), 64'(log32[k]), 64'(s_e32[k]));
        chk($sformatf("strm_imm64_%0d", k), log64[k], s_e64[k]);
        chk($sformatf("strm_fmt_%0d", k), 64'(logf[k]), 64'(s_fmt[k]));
      end

    // Backpressure: 4 stalled cycles, 3 offered
    clr_log();
    nacc = 0;
    for (int k = 0; k < 4; k++) begin
      step(nacc < 3, s_inst[nacc < 3 ? nacc : 0], 5'(nacc + 1), 0, 0, 0, f);
      if (f) nacc++;
    end
    chk("bp_accepts", 64'(nacc), 64'd2);
    chk("bp_inrdy", 64'(rdy32), 64'd0);
    for (int k = 0; k < 8; k++) begin
      step(nacc < 3, s_inst[nacc < 3 ? nacc : 0], 5'(nacc + 1), 1, 0, 0, f);
      if (f) nacc++;
    end
    chk("bp_cnt", 64'(logt.size()), 64'd3);
    if (logt.size() == 3)
      for (int k = 0; k < 3; k++) chk($sformatf("bp_order_%0d", k), 64'(logt[k]), 64'(k + 1));

    // Flush with two in flight and a same-cycle offer
    step(1, s_inst[0], 5'd10, 0, 0, 0, f);
    step(1, s_inst[1], 5'd11, 0, 0, 0, f);
    step(1, s_inst[2], 5'd12, 0, 1, 0, f);
    chk("fl_ov", 64'(ov32), 64'd0);
    chk("fl_inrdy", 64'(rdy32), 64'd1);
    step(1, 32'h13600093, 5'd13, 1, 0, 0, f);
    step(0, 0, 0, 1, 0, 0, f);
    chk("fl_next_vld", 64'(ov32), 64'd1);
    chk("fl_next_tag", 64'(tag32), 64'd13);
    step(0, 0, 0, 1, 0, 0, f);

    // CSRRWI
    step(1, 32'h3002D073, 5'd3, 1, 0, 0, f);
    step(0, 0, 0, 1, 0, 0, f);
`ifdef IMM_GEN_ZICSR_EN
    chk("csr_imm", 64'(imm32), 64'h5);
    chk("csr_fmt", 64'(fmt32), 64'd6);
`else
    chk("csr_imm", 64'(imm32), 64'h300);
    chk("csr_fmt", 64'(fmt32), 64'd1);
`endif
    step(0, 0, 0, 1, 0, 0, f);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      step($urandom_range(0, 3) != 0,
           {r[31:7], ops[$urandom_range(0, 11)]},
           5'($urandom()),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 300) == 0, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32I/RV64I core datapath. It takes raw 32-bit instruction words, picks the immediate format from the opcode, reassembles the immediate field, and sign-extends it to XLEN bits. It sits between fetch/decode and the ID/EX register, using valid/ready handshakes on both sides, a flush input and an optional Zicsr uimm mode. It replaces the combinational, XLEN-fixed ImmediateGenerator, which needed an immediate that had already been extracted.

## Interface
- XLEN, 32, datapath width; only 32 and 64 are legal.
- TAG_W, 5, width of the sideband tag passed through unchanged.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronously discards all in-flight entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband (e.g. ROB/PC index).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  encoding: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_tag  out  TAG_W  tag of the output entry.

## Operation
- Stage S1 registers in_inst and in_tag. Combinational decode sits between S1 and S2. Stage S2 registers out_imm, out_fmt and out_tag.
- Each stage has its own valid bit. A handshake fires when valid and ready are both 1 in the same cycle.
- s2_advance = !out_valid || out_ready.
- s1_advance = s1_valid && s2_advance.
- in_ready = !s1_valid || s2_advance. This is the only combinational path from out_ready to in_ready.
- Format selection uses the OPCODE_* header values:
  - I: JALR, LOAD, ITYPE, FENCE, ENVIRONMENT.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - Any other opcode (RTYPE, illegal): fmt NONE and imm 0.
- Field assembly:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- Every format is sign-extended from its top bit to XLEN. With XLEN=64, U-type is also sign-extended from bit 31.
- Entries leave in strict arrival order. No entry is dropped or duplicated except by flush or reset.

## Timing
- Reset, when reset_n=0 at an edge:
  - s1_valid and out_valid go to 0.
  - out_imm, out_fmt and out_tag go to 0.
  - The S1 data registers go to 0.
- in_ready is 1 in the first cycle after reset.
- Latency: an instruction accepted at edge N appears at out_valid=1 after edge N+1 (2-cycle register-to-register path).
- Throughput: 1 per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, out_imm, out_fmt and out_tag hold stable.
  - S1 may still fill once.
  - in_ready then drops to 0, leaving at most 2 entries buffered.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both honoured.
  - A full pipeline with out_ready=1 still accepts a new input.
- Flush: at the edge, s1_valid and out_valid are cleared.
  - flush has priority over a same-cycle input accept: the offered instruction is dropped.
  - Data registers need not be cleared.
- reset_n dominates flush.
- Reset or flush mid-backpressure loses the held entry without any output handshake.

## Configuration
- IMM_GEN_ZICSR_EN defined: for ENVIRONMENT with inst[14]=1 (CSRRWI/CSRRSI/CSRRCI), fmt is Z and imm is zero-extended inst[19:15].
- IMM_GEN_ZICSR_EN undefined: those instructions decode as I-type (imm is CSR address inst[31:20], sign-extended).

## Test plan
- Reset, then ADDI 0x13600093 with out_ready=1 → out_valid 2 edges later, imm 0x00000136, fmt 1, tag echoed.
- LW 0xB9F02083, BEQ 0xFE000EE3, AUIPC 0xDEADB017 and ADD 0x002081B3 sent back-to-back, XLEN=32 → imm 0xFFFFFB9F, 0xFFFFFFFC, 0xDEADB000, 0x00000000 on consecutive cycles; fmt 1, 3, 4, 0.
- Same stream with XLEN=64 → 0xFFFFFFFFFFFFFB9F, 0xFFFFFFFFFFFFFFFC, 0xFFFFFFFFDEADB000, 0.
- Backpressure: out_ready=0 for 4 cycles while 3 instructions are offered → in_ready drops after 2 accepts and the output holds stable. Then out_ready=1 → all 3 emerge in order and none are lost.
- Flush asserted with 2 entries in flight and in_valid=1 → next cycle out_valid=0 and in_ready=1. The next accepted instruction appears 2 edges later.
- CSRRWI 0x3002D073 → imm 0x00000005, fmt 6 with IMM_GEN_ZICSR_EN defined. Without the macro: imm 0x00000300, fmt 1.
